// File: rtl/serial_debug_ring_arb.sv
// serial_debug_ring_arb: round-robin owner of the serial debug ring.
// Shifts a frame out, collects the returned frame, reports to the owner.
module serial_debug_ring_arb #(
  parameter int NUM_REQ = 2,
  parameter int SF_BITS = 144,
  parameter int TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 prescaler,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*SF_BITS-1:0] req_frame,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [SF_BITS-1:0]         rsp_frame,
  output logic                       rsp_timeout,
  output logic                       busy,
  output logic [2:0]                 grant_id,
  input  logic                       debug_tx_data,
  input  logic                       debug_tx_clk,
  output logic                       debug_rx_data,
  output logic                       debug_rx_clk
);

  localparam int CW = $clog2(SF_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_TX_LOW, S_TX_HIGH, S_RX_WAIT, S_RESP
  } state_t;

  state_t             r_st;
  logic [SF_BITS-1:0] r_sh;
  logic [SF_BITS-1:0] r_rx;
  logic [SF_BITS-1:0] r_rsp_frame;
  logic [CW-1:0]      r_tx_cnt;
  logic [CW-1:0]      r_rx_cnt;
  logic [TW-1:0]      r_to;
  logic [7:0]         r_ph;
  logic [2:0]         r_ptr;
  logic [2:0]         r_gid;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_to;
  logic               r_busy;
  logic               r_dclk;
  logic               r_ddat;
  logic [2:0]         r_ck_s;
  logic [1:0]         r_dt_s;

  logic               w_edge;
  logic               w_bit;
  logic               w_rx_on;
  logic               w_take;
  logic [SF_BITS-1:0] w_rx_next;
  logic [CW-1:0]      w_cnt_next;
  logic               w_done;
  logic [7:0]         w_presc;
  logic               w_ph_end;
  logic               w_found;
  logic [2:0]         w_gid;
  logic [SF_BITS-1:0] w_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ck_s <= 3'b111;
      r_dt_s <= 2'b00;
    end else begin
      r_ck_s <= {r_ck_s[1:0], debug_tx_clk};
      r_dt_s <= {r_dt_s[0], debug_tx_data};
    end
  end

  assign w_edge = r_ck_s[1] & ~r_ck_s[2];
  assign w_bit  = r_dt_s[1];

  assign w_rx_on = (r_st == S_TX_LOW) || (r_st == S_TX_HIGH)
                || (r_st == S_RX_WAIT);
  assign w_take = w_rx_on && w_edge && (r_rx_cnt != CW'(SF_BITS));
  assign w_rx_next = w_take ? {r_rx[SF_BITS-2:0], w_bit} : r_rx;
  assign w_cnt_next = r_rx_cnt + {{(CW-1){1'b0}}, w_take};
  // Completion looks at this cycle's edge so it beats a same-cycle timeout
  assign w_done = (w_cnt_next == CW'(SF_BITS));

  assign w_presc  = (prescaler == 8'd0) ? 8'd1 : prescaler;
  assign w_ph_end = (r_ph == w_presc - 8'd1);

  // Last match wins, so the loop runs from lowest to highest priority
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_frame = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && (i == int'(r_ptr) + k ||
                             i == int'(r_ptr) + k - NUM_REQ)) begin
          w_found = 1'b1;
          w_gid   = 3'(i);
          w_frame = req_frame[i*SF_BITS +: SF_BITS];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st        <= S_IDLE;
      r_sh        <= '0;
      r_rx        <= '0;
      r_rsp_frame <= '0;
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_to        <= '0;
      r_ph        <= '0;
      r_ptr       <= 3'(NUM_REQ - 1);
      r_gid       <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_to    <= 1'b0;
      r_busy      <= 1'b0;
      r_dclk      <= 1'b1;
      r_ddat      <= 1'b0;
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      if (w_take) begin
        r_rx     <= w_rx_next;
        r_rx_cnt <= w_cnt_next;
      end
      if (w_edge) r_to <= '0;
      unique case (r_st)
        S_IDLE: begin
          if (w_found) begin
            r_sh        <= w_frame << 1;
            r_ddat      <= w_frame[SF_BITS-1];
            r_dclk      <= 1'b0;
            r_req_ready <= ONE << w_gid;
            r_gid       <= w_gid;
            r_ptr       <= w_gid;
            r_busy      <= 1'b1;
            r_rx        <= '0;
            r_rx_cnt    <= '0;
            r_to        <= '0;
            r_tx_cnt    <= CW'(1);
            r_ph        <= '0;
            r_st        <= S_TX_LOW;
          end
        end
        S_TX_LOW: begin
          if (w_ph_end) begin
            r_ph   <= '0;
            r_dclk <= 1'b1;
            r_st   <= S_TX_HIGH;
          end else begin
            r_ph <= r_ph + 8'd1;
          end
        end
        S_TX_HIGH: begin
          if (w_ph_end) begin
            r_ph <= '0;
            if (r_tx_cnt == CW'(SF_BITS)) begin
              r_to <= '0;
              r_st <= S_RX_WAIT;
            end else begin
              r_ddat   <= r_sh[SF_BITS-1];
              r_sh     <= r_sh << 1;
              r_dclk   <= 1'b0;
              r_tx_cnt <= r_tx_cnt + CW'(1);
              r_st     <= S_TX_LOW;
            end
          end else begin
            r_ph <= r_ph + 8'd1;
          end
        end
        S_RX_WAIT: begin
          if (w_done) begin
            r_rsp_frame <= w_rx_next;
            r_rsp_to    <= 1'b0;
            r_rsp_valid <= ONE << r_gid;
            r_busy      <= 1'b0;
            r_st        <= S_RESP;
          end else if (!w_edge && r_to == TW'(TIMEOUT - 1)) begin
            r_rsp_frame <= r_rx;
            r_rsp_to    <= 1'b1;
            r_rsp_valid <= ONE << r_gid;
            r_busy      <= 1'b0;
            r_st        <= S_RESP;
          end else if (!w_edge) begin
            r_to <= r_to + TW'(1);
          end
        end
        S_RESP:  r_st <= S_IDLE;
        default: r_st <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_frame     = r_rsp_frame;
  assign rsp_timeout   = r_rsp_to;
  assign busy          = r_busy;
  assign grant_id      = r_gid;
  assign debug_rx_data = r_ddat;
  assign debug_rx_clk  = r_dclk;

endmodule
